// File: rtl/pwm_multichannel_if.sv
// Register-side and pin-side signals of pwm_multichannel, bundled for the SPI register file.
// Define PWM_CENTER_ALIGN_EN to add the center_mode signal.
interface pwm_multichannel_if #(
  parameter int NUM_CH  = 16,
  parameter int RES     = 8,
  parameter int PRESC_W = 8
);
  localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]  en_out;
  logic [NUM_CH-1:0]  en_pwm;
  logic               duty_we;
  logic [AW-1:0]      duty_addr;
  logic [RES-1:0]     duty_wdata;
  logic [RES-1:0]     period_top;
  logic [PRESC_W-1:0] presc_div;
  logic [NUM_CH-1:0]  out;
  logic               period_start;
`ifdef PWM_CENTER_ALIGN_EN
  logic               center_mode;

  modport master (
    output en_out, en_pwm, duty_we, duty_addr, duty_wdata, period_top, presc_div, center_mode,
    input  out, period_start
  );
  modport slave (
    input  en_out, en_pwm, duty_we, duty_addr, duty_wdata, period_top, presc_div, center_mode,
    output out, period_start
  );
`else
  modport master (
    output en_out, en_pwm, duty_we, duty_addr, duty_wdata, period_top, presc_div,
    input  out, period_start
  );
  modport slave (
    input  en_out, en_pwm, duty_we, duty_addr, duty_wdata, period_top, presc_div,
    output out, period_start
  );
`endif
endinterface

// File: rtl/pwm_multichannel.sv
// N-channel PWM generator with prescaler and duty/top registers that reload only at the period boundary.
// Define PWM_CENTER_ALIGN_EN to add center_mode (up/down counting, latched at the boundary).
module pwm_multichannel #(
  parameter int NUM_CH  = 16,
  parameter int RES     = 8,
  parameter int PRESC_W = 8
) (
  input logic               clk,
  input logic               rst,
  pwm_multichannel_if.slave bus
);
  logic [PRESC_W-1:0] presc_cnt;
  logic [RES-1:0]     cnt;
  logic [RES-1:0]     active_top;
  logic [RES-1:0]     shadow_duty [NUM_CH];
  logic [RES-1:0]     active_duty [NUM_CH];
  logic [NUM_CH-1:0]  pwm;
  logic               tick;
  logic               boundary;
`ifdef PWM_CENTER_ALIGN_EN
  logic               dir_down;
  logic               active_center;
`endif

  // The >= compare lets a smaller presc_div take effect without waiting for a wrap.
  assign tick = (presc_cnt >= bus.presc_div);

`ifdef PWM_CENTER_ALIGN_EN
  assign boundary = tick && (active_center ?
                             ((cnt == '0) && (dir_down || (active_top == '0))) :
                             (cnt == active_top));
`else
  assign boundary = tick && (cnt == active_top);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc_cnt <= '0;
    else     presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      active_top    <= '1;
`ifdef PWM_CENTER_ALIGN_EN
      dir_down      <= 1'b0;
      active_center <= 1'b0;
`endif
    end else if (boundary) begin
      active_top    <= bus.period_top;
`ifdef PWM_CENTER_ALIGN_EN
      // The zero at the bottom of a centred period belongs to the boundary tick, so restart at 1.
      active_center <= bus.center_mode;
      dir_down      <= 1'b0;
      cnt           <= (bus.center_mode && (bus.period_top != '0)) ? RES'(1) : '0;
`else
      cnt           <= '0;
`endif
    end else if (tick) begin
`ifdef PWM_CENTER_ALIGN_EN
      if (active_center) begin
        if (dir_down) begin
          cnt <= cnt - RES'(1);
        end else if (cnt == active_top) begin
          dir_down <= 1'b1;
          cnt      <= cnt - RES'(1);
        end else begin
          cnt <= cnt + RES'(1);
        end
      end else begin
        cnt <= cnt + RES'(1);
      end
`else
      cnt <= cnt + RES'(1);
`endif
    end
  end

  // Non-blocking reload means a write landing on the boundary edge is seen one period later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_duty[i] <= '0;
        active_duty[i] <= '0;
      end
    end else begin
      if (boundary) begin
        for (int i = 0; i < NUM_CH; i++) active_duty[i] <= shadow_duty[i];
      end
      if (bus.duty_we && (int'(bus.duty_addr) < NUM_CH)) begin
        shadow_duty[bus.duty_addr] <= bus.duty_wdata;
      end
    end
  end

  always_comb begin
    pwm = '0;
    for (int i = 0; i < NUM_CH; i++) pwm[i] = (cnt < active_duty[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out          <= '0;
      bus.period_start <= 1'b0;
    end else begin
      bus.out          <= bus.en_out & (~bus.en_pwm | pwm);
      bus.period_start <= boundary;
    end
  end
endmodule

// File: tb/tb_pwm_multichannel.sv
// Scoreboard bench for pwm_multichannel: expected high counts per window are queued when a
// scenario is set up and popped as each measurement window completes.
module tb_pwm_multichannel;
  localparam int NUM_CH  = 12;
  localparam int RES     = 8;
  localparam int PRESC_W = 8;
  localparam int AW      = $clog2(NUM_CH);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   hi_cnt [NUM_CH];
  int   start_cnt;
  string tag_q [$];
  int    exp_q [$];

  always #5 clk = ~clk;

  pwm_multichannel_if #(.NUM_CH(NUM_CH), .RES(RES), .PRESC_W(PRESC_W)) bus ();

  pwm_multichannel #(.NUM_CH(NUM_CH), .RES(RES), .PRESC_W(PRESC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expectVal(input string tag, input int v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic checkNext(input int obs);
    if (exp_q.size() == 0) checkOutput("scoreboard_empty", obs, -1);
    else checkOutput(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic applyStimulus(input logic [RES-1:0] top, input logic [PRESC_W-1:0] presc,
                               input logic [NUM_CH-1:0] eo, input logic [NUM_CH-1:0] ep);
    bus.period_top = top;
    bus.presc_div  = presc;
    bus.en_out     = eo;
    bus.en_pwm     = ep;
  endtask

  task automatic writeDuty(input int ch, input logic [RES-1:0] val);
    bus.duty_we    = 1'b1;
    bus.duty_addr  = AW'(ch);
    bus.duty_wdata = val;
    @(negedge clk);
    bus.duty_we    = 1'b0;
  endtask

  task automatic waitStart();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.period_start && n < 2000);
    if (!bus.period_start) checkOutput("period_start_timeout", 0, 1);
  endtask

  task automatic settle();
    waitStart();
    waitStart();
  endtask

  task automatic measure(input int n);
    for (int c = 0; c < NUM_CH; c++) hi_cnt[c] = 0;
    start_cnt = 0;
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) hi_cnt[c] += int'(bus.out[c]);
      start_cnt += int'(bus.period_start);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.duty_we    = 1'b0;
    bus.duty_addr  = '0;
    bus.duty_wdata = '0;
`ifdef PWM_CENTER_ALIGN_EN
    bus.center_mode = 1'b0;
`endif
    applyStimulus(8'd255, 8'd0, '0, '0);
    repeat (2) @(negedge clk);
    checkOutput("reset_out", int'(bus.out), 0);
    checkOutput("reset_period_start", int'(bus.period_start), 0);

    // Reset in the middle of a period with all outputs driven high.
    rst = 1'b0;
    applyStimulus(8'd255, 8'd0, '1, '0);
    repeat (40) @(negedge clk);
    checkOutput("static_high_before_rst", int'(bus.out), (1 << NUM_CH) - 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_out", int'(bus.out), 0);
    checkOutput("async_rst_cnt", int'(dut.cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'd255, 8'd0, '1, '0);
    repeat (2) @(negedge clk);
    checkOutput("release_out_all_high", int'(bus.out), (1 << NUM_CH) - 1);

    // 50 % duty on channel 3 over a full 256-clk period.
    applyStimulus(8'd255, 8'd0, '1, '1);
    expectVal("t2_ch3_high", 128);
    expectVal("t2_ch0_high", 0);
    expectVal("t2_starts", 1);
    writeDuty(3, 8'd128);
    settle();
    measure(256);
    checkNext(hi_cnt[3]);
    checkNext(hi_cnt[0]);
    checkNext(start_cnt);

    // Duty edge cases with top=9, two periods.
    applyStimulus(8'd9, 8'd0, '1, '1);
    expectVal("t3_duty0", 0);
    expectVal("t3_duty10", 20);
    expectVal("t3_duty5", 10);
    expectVal("t3_duty128", 20);
    expectVal("t3_starts", 2);
    writeDuty(0, 8'd0);
    writeDuty(1, 8'd10);
    writeDuty(2, 8'd5);
    settle();
    measure(20);
    checkNext(hi_cnt[0]);
    checkNext(hi_cnt[1]);
    checkNext(hi_cnt[2]);
    checkNext(hi_cnt[3]);
    checkNext(start_cnt);

    // Mid-period write holds until the boundary.
    waitStart();
    repeat (3) @(negedge clk);
    expectVal("t4_hold_ch0", 0);
    expectVal("t4_hold_starts", 1);
    expectVal("t4_new_ch0", 10);
    expectVal("t4_new_starts", 1);
    writeDuty(0, 8'd200);
    measure(6);
    checkNext(hi_cnt[0]);
    checkNext(start_cnt);
    measure(10);
    checkNext(hi_cnt[0]);
    checkNext(start_cnt);

    // Write on the boundary clk: old shadow loads now, new value one period later.
    repeat (9) @(negedge clk);
    expectVal("t4_same_clk_start", 1);
    expectVal("t4_same_clk_old", 10);
    expectVal("t4_same_clk_starts", 1);
    expectVal("t4_same_clk_new", 0);
    writeDuty(0, 8'd0);
    checkNext(int'(bus.period_start));
    measure(10);
    checkNext(hi_cnt[0]);
    checkNext(start_cnt);
    measure(10);
    checkNext(hi_cnt[0]);

    // Prescaler: 4 clks per tick, top=3 gives a 16-clk period.
    applyStimulus(8'd3, 8'd3, '1, '1);
    expectVal("t5_ch2_high", 8);
    expectVal("t5_ch1_full", 16);
    expectVal("t5_starts", 1);
    expectVal("t5_starts_2p", 2);
    writeDuty(2, 8'd2);
    settle();
    measure(16);
    checkNext(hi_cnt[2]);
    checkNext(hi_cnt[1]);
    checkNext(start_cnt);
    measure(32);
    checkNext(start_cnt);

    // Out-of-range writes, a disabled channel and a static-high channel.
    begin
      logic [NUM_CH-1:0] eo;
      logic [NUM_CH-1:0] ep;
      eo = '1;
      ep = '1;
      eo[3] = 1'b0;
      ep[4] = 1'b0;
      applyStimulus(8'd3, 8'd3, eo, ep);
      for (int c = 0; c < NUM_CH; c++) begin
        int e;
        case (c)
          1:       e = 16;
          2:       e = 8;
          4:       e = 16;
          default: e = 0;
        endcase
        expectVal($sformatf("t5_ch%0d_after_bad_addr", c), e);
      end
      writeDuty(NUM_CH, 8'd77);
      writeDuty((1 << AW) - 1, 8'd99);
      settle();
      measure(16);
      for (int c = 0; c < NUM_CH; c++) checkNext(hi_cnt[c]);
    end

`ifdef PWM_CENTER_ALIGN_EN
    // Centre-aligned: top=4 gives an 8-tick period, duty 2 high for cnt 0,1 (3 ticks).
    bus.center_mode = 1'b1;
    applyStimulus(8'd4, 8'd0, '1, '1);
    expectVal("t6_ch2_high", 3);
    expectVal("t6_ch1_full", 8);
    expectVal("t6_starts", 1);
    settle();
    measure(8);
    checkNext(hi_cnt[2]);
    checkNext(hi_cnt[1]);
    checkNext(start_cnt);
`endif

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
